// File: rtl/sd_audio_streamer.sv
// sd_audio_streamer: streams SD sectors through a byte FIFO and releases one PCM sample per tick.
// Optional SD_AUDIO_LOOP_EN: wrap to START_ADDR after NUM_SECTORS for gapless looping.
module sd_audio_streamer #(
  parameter logic [31:0] START_ADDR  = 32'h0000_0000,
  parameter int          ADDR_STEP   = 512,
  parameter int          NUM_SECTORS = 4096,
  parameter int          SAMPLE_DIV  = 3125,
  parameter int          FIFO_DEPTH  = 1024
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          start,
  input  logic                          sd_ready,
  input  logic [7:0]                    sd_dout,
  input  logic                          sd_byte_available,
  output logic                          sd_rd,
  output logic [31:0]                   sd_addr,
  output logic [7:0]                    music_data,
  output logic                          sample_strobe,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          underrun,
  output logic                          done
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = $clog2(SAMPLE_DIV + 1);
  localparam int SW = $clog2(NUM_SECTORS + 1);
  typedef enum logic [2:0] {IDLE, WAIT, REQ, READ, FLUSH, NEXT, DRAIN, DONE} state_t;
  state_t state, state_nx;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [8:0] byte_cnt;
  logic [SW-1:0] sec_cnt;
  logic [TW-1:0] tick_cnt;
  logic avail_q, playing, edge_s, active, tick, empty, push, pop, last_byte, last_sec;
  assign edge_s = sd_byte_available & ~avail_q;
  assign active = state != IDLE && state != DONE;
  assign tick = active && tick_cnt == TW'(SAMPLE_DIV - 1);
  assign empty = fifo_level == '0;
  assign push = !start && state == READ && edge_s;
  assign pop = !start && tick && playing && !empty;
  assign last_byte = edge_s && byte_cnt == 9'd511;
  assign last_sec = sec_cnt == SW'(NUM_SECTORS - 1);
  assign sd_rd = state == REQ;
  assign done = state == DONE;
  always_comb begin
    state_nx = state;
    case (state)
      WAIT:        if (sd_ready && fifo_level <= LW'(FIFO_DEPTH - 512)) state_nx = REQ;
      REQ:         if (!sd_ready) state_nx = READ;
      READ, FLUSH: if (last_byte) state_nx = state == READ ? NEXT : WAIT;
`ifdef SD_AUDIO_LOOP_EN
      NEXT:        state_nx = WAIT;
`else
      NEXT:        state_nx = last_sec ? DRAIN : WAIT;
`endif
      DRAIN:       if (empty) state_nx = DONE;
      default:     state_nx = state;
    endcase
    // a restart mid-sector must still swallow the bytes the controller keeps sending
    if (start) state_nx = (state == READ || state == FLUSH) && !last_byte ? FLUSH : WAIT;
  end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= sd_dout;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      sd_addr <= START_ADDR;
      music_data <= 8'h80;
      sample_strobe <= 1'b0;
      fifo_level <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      underrun <= 1'b0;
      tick_cnt <= '0;
      sec_cnt <= '0;
      byte_cnt <= '0;
      avail_q <= 1'b0;
      playing <= 1'b0;
    end else begin
      state <= state_nx;
      avail_q <= sd_byte_available;
      sample_strobe <= pop;
      if (pop) music_data <= mem[rd_ptr];
      tick_cnt <= (!active || start || tick) ? '0 : tick_cnt + 1'b1;
      if (state == REQ) byte_cnt <= '0;
      else if ((state == READ || state == FLUSH) && edge_s) byte_cnt <= byte_cnt + 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      fifo_level <= fifo_level + LW'(push) - LW'(pop);
      if (fifo_level >= LW'(512)) playing <= 1'b1;
      if (tick && playing && empty && state != DRAIN) underrun <= 1'b1;
      if (state == NEXT) begin
`ifdef SD_AUDIO_LOOP_EN
        sd_addr <= last_sec ? START_ADDR : sd_addr + 32'(ADDR_STEP);
        sec_cnt <= last_sec ? '0 : sec_cnt + 1'b1;
`else
        sd_addr <= sd_addr + 32'(ADDR_STEP);
        sec_cnt <= sec_cnt + 1'b1;
`endif
      end
      if (start) begin
        sd_addr <= START_ADDR;
        sec_cnt <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
        fifo_level <= '0;
        underrun <= 1'b0;
        playing <= 1'b0;
        music_data <= 8'h80;
        sample_strobe <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_sd_audio_streamer.sv
// tb_sd_audio_streamer: directed bench with an SD controller model and a sample monitor.
module tb_sd_audio_streamer;
  localparam int DIV = 20;
  localparam int NS = 2;
  localparam int DEPTH = 1024;
  localparam logic [31:0] SA = 32'h0000_1000;
  logic clk = 0, reset_n = 0, start = 1, sd_ready = 1, sd_byte_available = 0;
  logic [7:0] sd_dout = 0;
  logic sd_rd, sample_strobe, underrun, done;
  logic [31:0] sd_addr;
  logic [7:0] music_data;
  logic [10:0] fifo_level;
  int errors = 0, checks = 0, idx = 0, cur_k = 0, cyc = 0, last_cyc = 0;
  bit have_last = 0;
  sd_audio_streamer #(.START_ADDR(SA), .ADDR_STEP(512), .NUM_SECTORS(NS), .SAMPLE_DIV(DIV),
                      .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .sd_ready(sd_ready), .sd_dout(sd_dout),
    .sd_byte_available(sd_byte_available), .sd_rd(sd_rd), .sd_addr(sd_addr),
    .music_data(music_data), .sample_strobe(sample_strobe), .fifo_level(fifo_level),
    .underrun(underrun), .done(done));
  always #5 clk = ~clk;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // sector k byte j carries j + 16k, so every sector's stream is distinguishable
  function automatic logic [7:0] pat(int k, int i);
    return 8'(i % 512 + 16 * (k + i / 512));
  endfunction
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (sample_strobe) begin
      check("sample", music_data, pat(cur_k, idx));
      if (have_last) check("interval", 32'(cyc - last_cyc), DIV);
      have_last = 1;
      last_cyc = cyc;
      idx++;
    end
    if (fifo_level > 11'(DEPTH)) check("fifo_ovf", fifo_level, DEPTH);
  end
  task automatic pulse_start(int k);
    @(negedge clk) start = 1;
    idx = 0; cur_k = k; have_last = 0;
    @(negedge clk) start = 0;
  endtask
  task automatic serve(int k, logic [31:0] a, bit stall, int abort, int nk, bit fill);
    int n = 0;
    while (!sd_rd && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("req", sd_rd, 1);
    check("addr", sd_addr, a);
    sd_ready = 0;
    @(negedge clk);
    check("rd_drop", sd_rd, 0);
    for (int j = 0; j < 512; j++) begin
      sd_dout = pat(k, j);
      sd_byte_available = 1;
      @(negedge clk);
      if (fill && j == 511) check("fill", fifo_level, 512);
      repeat (2) @(negedge clk);
      sd_byte_available = 0;
      if (j == abort) begin
        start = 1; idx = 0; cur_k = nk; have_last = 0;
      end
      @(negedge clk);
      if (j == abort) begin
        start = 0;
        check("flush_level", fifo_level, 0);
        check("flush_addr", sd_addr, SA);
      end
    end
    sd_ready = !stall;
  endtask
  initial begin
    int n;
    int rd_seen;
    repeat (3) @(negedge clk);
    check("rst_rd", sd_rd, 0);
    check("rst_addr", sd_addr, SA);
    check("rst_music", music_data, 8'h80);
    check("rst_strobe", sample_strobe, 0);
    check("rst_level", fifo_level, 0);
    check("rst_underrun", underrun, 0);
    check("rst_done", done, 0);
    start = 0;
    @(negedge clk) reset_n = 1;
    pulse_start(0);
    check("lat1", sd_rd, 0);
    @(negedge clk);
    check("lat2", sd_rd, 1);
    serve(0, SA, 0, -1, 0, 1);
    check("done_early", done, 0);
    serve(1, SA + 512, 0, -1, 0, 0);
    n = 0;
    while (!done && n < 40000) begin
      @(negedge clk);
      n++;
    end
    check("done", done, 1);
    check("samples", idx, 1024);
    check("last_music", music_data, 8'h0f);
    check("no_underrun", underrun, 0);
    check("end_addr", sd_addr, SA + 1024);
    rd_seen = 0;
    repeat (50) begin
      @(negedge clk);
      if (sd_rd) rd_seen++;
    end
    check("rd_after_done", rd_seen, 0);
    check("done_hold", done, 1);
    pulse_start(0);
    check("restart_done", done, 0);
    check("restart_level", fifo_level, 0);
    check("restart_music", music_data, 8'h80);
    check("restart_addr", sd_addr, SA);
    serve(0, SA, 1, -1, 0, 1);
    n = 0;
    while (!underrun && n < 15000) begin
      @(negedge clk);
      n++;
    end
    check("underrun", underrun, 1);
    check("ur_samples", idx, 512);
    check("ur_music", music_data, 8'hff);
    repeat (3 * DIV) @(negedge clk);
    check("ur_no_strobe", idx, 512);
    check("ur_hold", music_data, 8'hff);
    pulse_start(2);
    check("ur_clear", underrun, 0);
    check("ur_music_reset", music_data, 8'h80);
    sd_ready = 1;
    serve(5, SA, 0, 100, 2, 0);
    serve(2, SA, 0, -1, 0, 1);
    n = 0;
    while (idx < 4 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("post_flush_play", 32'(idx >= 4), 1);
    check("post_flush_underrun", underrun, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
